// File: rtl/ets_phase_sweeper.sv
// Equivalent-time-sampling sweep sequencer: walks the MMCM phase shifter across N points,
// counts comparator hits per point into the capture buffer, then unwinds to the origin.
module ets_phase_sweeper #(
    parameter int ADDR_WIDTH    = 9,
    parameter int STEP_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int PS_TIMEOUT    = 64
) (
    input  logic                  S_AXI_DATA_aclk,
    input  logic                  S_AXI_DATA_aresetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   num_points,
    input  logic [STEP_WIDTH-1:0] steps_per_point,
    input  logic [31:0]           avg_count,
    input  logic                  trigger,
    input  logic                  cmp_sample,
    output logic                  ps_en,
    output logic                  ps_incdec,
    input  logic                  ps_done,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic [31:0]           phase_counter,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int IW = ADDR_WIDTH + 1;
    localparam logic [IW-1:0] MAX_POINTS   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [7:0]    SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [9:0]    TIMEOUT_LAST = 10'(PS_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SETTLE, S_ACQ, S_WRITE, S_SHIFT,
        S_WAIT_DONE, S_UNWIND_CHK, S_USHIFT, S_DONE, S_ERR
    } state_t;

    state_t state, state_n;

    logic [IW-1:0]         npts, idx, idx_inc;
    logic [STEP_WIDTH-1:0] steps, step_cnt;
    logic [31:0]           avg, events, hits, ev_inc, hit_inc;
    logic [7:0]            settle_cnt;
    logic [9:0]            to_cnt;
    logic                  unwind, abort_pend, last_event;

    assign idx_inc    = idx + IW'(1);
    assign ev_inc     = events + 32'd1;
    assign hit_inc    = hits + {31'd0, cmp_sample};
    assign last_event = trigger && (ev_inc == avg);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:       if (start) state_n = (num_points == '0) ? S_DONE : S_SETTLE;
            S_SETTLE:     if (abort) state_n = S_UNWIND_CHK;
                          else if (settle_cnt == SETTLE_LAST) state_n = S_ACQ;
            S_ACQ:        if (abort) state_n = S_UNWIND_CHK;
                          else if (last_event) state_n = S_WRITE;
            S_WRITE:      if (idx_inc == npts) state_n = S_UNWIND_CHK;
                          else if (steps == '0) state_n = S_SETTLE;
                          else state_n = S_SHIFT;
            S_SHIFT:      state_n = S_WAIT_DONE;
            S_WAIT_DONE: begin
                // ps_done wins over a timeout expiring in the same cycle
                if (ps_done) begin
                    if (unwind || abort_pend || abort) state_n = S_UNWIND_CHK;
                    else if (step_cnt > STEP_WIDTH'(1)) state_n = S_SHIFT;
                    else state_n = S_SETTLE;
                end else if (to_cnt == TIMEOUT_LAST) begin
                    state_n = S_ERR;
                end
            end
            S_UNWIND_CHK: state_n = (phase_counter == 32'd0) ? S_DONE : S_USHIFT;
            S_USHIFT:     state_n = S_WAIT_DONE;
            S_DONE:       state_n = S_IDLE;
            S_ERR:        state_n = S_IDLE;
            default:      state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_DATA_aclk) begin
        if (!S_AXI_DATA_aresetn) begin
            state         <= S_IDLE;
            npts          <= '0;
            idx           <= '0;
            steps         <= '0;
            step_cnt      <= '0;
            avg           <= '0;
            events        <= '0;
            hits          <= '0;
            settle_cnt    <= '0;
            to_cnt        <= '0;
            unwind        <= 1'b0;
            abort_pend    <= 1'b0;
            ps_en         <= 1'b0;
            ps_incdec     <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            phase_counter <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state      <= state_n;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 8'd1 : 8'd0;
            to_cnt     <= (state == S_WAIT_DONE) ? to_cnt + 10'd1 : 10'd0;
            busy       <= (state_n != S_IDLE);
            done       <= (state == S_DONE);
            ps_en      <= 1'b0;
            wr_en      <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    npts       <= (num_points > MAX_POINTS) ? MAX_POINTS : num_points;
                    steps      <= steps_per_point;
                    avg        <= (avg_count == 32'd0) ? 32'd1 : avg_count;
                    idx        <= '0;
                    events     <= '0;
                    hits       <= '0;
                    unwind     <= 1'b0;
                    abort_pend <= 1'b0;
                    error      <= 1'b0;
                end
                S_ACQ: if (trigger && !abort) begin
                    events <= ev_inc;
                    hits   <= hit_inc;
                    if (last_event) begin
                        wr_en   <= 1'b1;
                        wr_addr <= idx[ADDR_WIDTH-1:0];
                        wr_data <= hit_inc;
                    end
                end
                S_WRITE: begin
                    events   <= '0;
                    hits     <= '0;
                    idx      <= idx_inc;
                    step_cnt <= steps;
                    if (state_n == S_SHIFT) begin
                        ps_en     <= 1'b1;
                        ps_incdec <= 1'b1;
                    end
                end
                // PSEN is already out in SHIFT, so an abort here must wait for its ps_done
                S_SHIFT: if (abort) abort_pend <= 1'b1;
                S_WAIT_DONE: begin
                    if (abort && !unwind) abort_pend <= 1'b1;
                    if (ps_done) begin
                        phase_counter <= unwind ? phase_counter - 32'd1 : phase_counter + 32'd1;
                        step_cnt      <= step_cnt - STEP_WIDTH'(1);
                    end
                    if (state_n == S_SHIFT) begin
                        ps_en     <= 1'b1;
                        ps_incdec <= 1'b1;
                    end
                end
                S_UNWIND_CHK: if (state_n == S_USHIFT) begin
                    unwind    <= 1'b1;
                    ps_en     <= 1'b1;
                    ps_incdec <= 1'b0;
                end
                S_ERR: error <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ets_phase_sweeper.sv
// Randomized scoreboard bench for ets_phase_sweeper: sweeps are driven with a timing-aware
// stimulus; a monitor checks writes, phase-shift traffic and terminal status.
module tb_ets_phase_sweeper;
    localparam int AW     = 3;
    localparam int SW     = 8;
    localparam int SETTLE = 16;
    localparam int TMO    = 64;
    localparam int MAXP   = 1 << AW;

    logic          clk = 1'b0;
    logic          aresetn, start, abort, trigger, cmp_sample, ps_done;
    logic [AW:0]   num_points;
    logic [SW-1:0] steps_per_point;
    logic [31:0]   avg_count;
    logic          ps_en, ps_incdec, wr_en, busy, done, error;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data, phase_counter;

    always #5 clk = ~clk;

    ets_phase_sweeper #(.ADDR_WIDTH(AW), .STEP_WIDTH(SW), .SETTLE_CYCLES(SETTLE), .PS_TIMEOUT(TMO)) dut (
        .S_AXI_DATA_aclk(clk), .S_AXI_DATA_aresetn(aresetn), .start(start), .abort(abort),
        .num_points(num_points), .steps_per_point(steps_per_point), .avg_count(avg_count),
        .trigger(trigger), .cmp_sample(cmp_sample), .ps_en(ps_en), .ps_incdec(ps_incdec),
        .ps_done(ps_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .phase_counter(phase_counter), .busy(busy), .done(done), .error(error)
    );

    typedef struct { int addr; int data; } wr_t;
    typedef struct { bit err; int incs; int decs; int phase; int busy_cyc; } sw_t;

    wr_t wr_q[$];
    sw_t sw_q[$];
    int  tests = 0, fails = 0;
    int  carry = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        int cyc = 0, incs = 0, decs = 0, busy_cyc = 0, rise_cyc = 0, psen_cyc = 0, mphase = 0, lat;
        bit outst = 0, dir = 0, prev_busy = 0, prev_err = 0, prev_psen = 0;
        wr_t w;
        sw_t r;
        forever begin
            @(posedge clk); #1; cyc++;
            if (!aresetn || !mon_en) begin
                incs = 0; decs = 0; busy_cyc = 0; mphase = 0; outst = 0;
                prev_busy = 0; prev_err = 0; prev_psen = 0;
                continue;
            end
            if (ps_done) begin
                if (outst) begin
                    mphase = dir ? mphase + 1 : mphase - 1;
                    outst = 0;
                end
                check("phase_on_ps_done", $signed(phase_counter), mphase);
            end
            if (ps_en) begin
                check("ps_en_single_cycle", prev_psen, 0);
                check("ps_en_while_outstanding", outst, 0);
                outst = 1; dir = ps_incdec; psen_cyc = cyc;
                if (ps_incdec) incs++; else decs++;
            end
            if (wr_en) begin
                check("wr_expected", wr_q.size() > 0, 1);
                if (wr_q.size() > 0) begin
                    w = wr_q.pop_front();
                    check("wr_addr", wr_addr, w.addr);
                    check("wr_data", wr_data, w.data);
                end
            end
            if (busy && !prev_busy) begin
                check("error_cleared_on_start", error, 0);
                rise_cyc = cyc;
            end
            if (busy) busy_cyc++;
            if (done || (error && !prev_err)) begin
                check("sweep_expected", sw_q.size() > 0, 1);
                if (sw_q.size() > 0) begin
                    r = sw_q.pop_front();
                    check("terminal_is_error", error && !prev_err, r.err);
                    check("terminal_ps_increments", incs, r.incs);
                    check("terminal_ps_decrements", decs, r.decs);
                    check("terminal_phase", $signed(phase_counter), r.phase);
                    check("terminal_busy", busy, 0);
                    check("terminal_pending_writes", wr_q.size(), 0);
                    if (r.busy_cyc >= 0) begin
                        check("busy_cycles", busy_cyc, r.busy_cyc);
                        check("done_latency", cyc - rise_cyc, 1);
                    end
                    if (r.err) begin
                        lat = cyc - psen_cyc;
                        check("timeout_latency_in_range", (lat >= TMO) && (lat <= TMO + 3), 1);
                    end
                end
                incs = 0; decs = 0; busy_cyc = 0; outst = 0;
            end
            prev_busy = busy; prev_err = error; prev_psen = ps_en;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_ps_en"}, ps_en, 0);
        check({tag, "_ps_incdec"}, ps_incdec, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_phase"}, phase_counter, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    task automatic wait_psen(output bit ok);
        int n = 0;
        while (!ps_en && n < 300) begin @(negedge clk); n++; end
        ok = ps_en;
        check("ps_en_arrives", ps_en, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        check("returns_idle", busy, 0);
    endtask

    task automatic unwind_respond(input int lat);
        int n = 0;
        while (busy && n < 3000) begin
            if (ps_en) begin
                repeat (lat) @(negedge clk);
                ps_done = 1'b1; @(negedge clk); ps_done = 1'b0;
                n += lat + 1;
            end else begin
                @(negedge clk); n++;
            end
        end
        check("unwind_completes", busy, 0);
    endtask

    // cmode: 0 random, 1 alternating 1/0, 2 all ones
    task automatic run_sweep(input int np, input int stp, input int avg, input int lat,
                             input int abort_pt, input int hold_step, input int cmode);
        int  npe, avg_e, full, hits, nstep, gap;
        bit  c, ok;
        sw_t r;
        npe   = (np > MAXP) ? MAXP : np;
        avg_e = (avg == 0) ? 1 : avg;
        full  = (abort_pt >= 0 && abort_pt < npe) ? abort_pt : ((npe > 0) ? npe - 1 : 0);
        nstep = 0;
        r.busy_cyc = (npe == 0) ? 1 : -1;
        if (npe == 0) begin
            r.err = 0; r.incs = 0; r.decs = 0; r.phase = carry;
        end else if (hold_step > 0) begin
            r.err = 1; r.incs = hold_step; r.decs = 0; r.phase = carry + hold_step - 1;
        end else begin
            r.err = 0; r.incs = full * stp; r.decs = full * stp + carry; r.phase = 0;
        end
        carry = r.phase;
        sw_q.push_back(r);

        @(negedge clk);
        start = 1'b1; num_points = (AW + 1)'(np); steps_per_point = SW'(stp); avg_count = avg;
        @(negedge clk);
        start = 1'b0;
        if (npe == 0) begin wait_idle(); return; end
        for (int i = 0; i < npe; i++) begin
            // the trigger in the last settle cycle must be ignored
            for (int s = 0; s < SETTLE; s++) begin
                trigger = (s == SETTLE - 1); cmp_sample = 1'b1;
                if (i == 1 && s == 0) begin start = 1'b1; num_points = '0; end
                @(negedge clk);
                start = 1'b0; num_points = (AW + 1)'(np);
            end
            trigger = 1'b0;
            if (i == abort_pt) begin
                for (int e = 0; e < ((avg_e - 1 < 2) ? avg_e - 1 : 2); e++) begin
                    trigger = 1'b1; cmp_sample = 1'b1; @(negedge clk);
                end
                trigger = 1'b0; abort = 1'b1; @(negedge clk); abort = 1'b0;
                unwind_respond(lat);
                return;
            end
            hits = 0;
            for (int e = 0; e < avg_e; e++) begin
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
                case (cmode)
                    0:       c = 1'($urandom_range(0, 1));
                    1:       c = (e % 2 == 0);
                    default: c = 1'b1;
                endcase
                trigger = 1'b1; cmp_sample = c; hits += int'(c);
                if (e == avg_e - 1) wr_q.push_back('{i, hits});
                @(negedge clk);
                trigger = 1'b0;
            end
            // trigger coinciding with the write strobe is not counted
            trigger = 1'b1; cmp_sample = 1'b1; @(negedge clk); trigger = 1'b0;
            if (i == npe - 1) break;
            for (int k = 0; k < stp; k++) begin
                wait_psen(ok);
                if (!ok) begin wait_idle(); return; end
                nstep++;
                if (nstep == hold_step) begin wait_idle(); return; end
                repeat (lat) @(negedge clk);
                ps_done = 1'b1; @(negedge clk); ps_done = 1'b0;
            end
        end
        unwind_respond(lat);
    endtask

    task automatic reset_mid_sweep();
        bit ok;
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1; num_points = 4; steps_per_point = 1; avg_count = 2;
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE) @(negedge clk);
        trigger = 1'b1; cmp_sample = 1'b1;
        repeat (2) @(negedge clk);
        trigger = 1'b0;
        wait_psen(ok);
        repeat (3) @(negedge clk);
        ps_done = 1'b1; @(negedge clk); ps_done = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_sweep_busy_before_reset", busy, 1);
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("in_reset");
        aresetn = 1'b1;
        @(negedge clk);
        check_reset_vals("after_reset");
        carry = 0;
        mon_en = 1'b1;
    endtask

    initial begin
        aresetn = 1'b0; start = 1'b0; abort = 1'b0; trigger = 1'b0; cmp_sample = 1'b0;
        ps_done = 1'b0; num_points = '0; steps_per_point = '0; avg_count = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        aresetn = 1'b1; mon_en = 1'b1;
        @(negedge clk);

        run_sweep(4, 2, 8, 12, -1, -1, 1);
        run_sweep(0, 1, 4, 3, -1, -1, 0);
        run_sweep(3, 1, 0, 4, -1, -1, 2);
        run_sweep(4, 3, 5, 6, 2, -1, 0);
        run_sweep(5, 1, 8, 5, -1, 3, 0);
        // stray ps_done while idle must leave the phase untouched
        ps_done = 1'b1; @(negedge clk); ps_done = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_ps_done_phase", $signed(phase_counter), carry);
        run_sweep(12, 0, 1, 1, -1, -1, 0);
        for (int n = 0; n < 4; n++)
            run_sweep($urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 6),
                      $urandom_range(1, 6), -1, -1, 0);
        reset_mid_sweep();
        run_sweep(2, 2, 3, 2, -1, -1, 0);
        repeat (5) @(negedge clk);
        check("sweeps_drained", sw_q.size(), 0);
        check("writes_drained", wr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
